// File: rtl/riscv_mem_arbiter_pkg.sv
// rtl/riscv_mem_arbiter_pkg.sv - shared types for the fetch/data memory arbiter
//
// Purpose: owner and state enums, the latched-request struct and the
// arbitration rule shared by the arbiter and anything that inspects it.
package riscv_mem_arbiter_pkg;

  localparam int ARB_XLEN = 32;

  typedef enum logic {
    OWNER_IFETCH,
    OWNER_DATA
  } mem_owner_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_RESP
  } arb_state_t;

  // Request captured at grant time; the memory side is driven only from this.
  typedef struct packed {
    logic                  we;
    logic [ARB_XLEN-1:0]   addr;
    logic [ARB_XLEN-1:0]   wdata;
    logic [ARB_XLEN/8-1:0] wstrb;
  } mem_req_t;

  // Data has priority unless fetch is waiting and has already lost too often.
  function automatic logic data_wins(input logic d_req, input logic if_req,
                                     input logic starved);
    return d_req && !(if_req && starved);
  endfunction

endpackage

// File: rtl/riscv_mem_arbiter_if.sv
// rtl/riscv_mem_arbiter_if.sv - fetch, data and memory handshake bundle
//
// Purpose: groups the fetch requester, data requester and memory bus signals.
// Ports (slave = arbiter view):
//   fetch : if_req/if_addr/if_flush in, if_gnt/if_rvalid/if_rdata out
//   data  : d_req/d_we/d_addr/d_wdata/d_wstrb in, d_gnt/d_rvalid/d_rdata out
//   memory: mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb out,
//           mem_gnt/mem_rvalid/mem_rdata in
//   status: proto_err out
interface riscv_mem_arbiter_if #(
  parameter int XLEN = 32
);
  logic              if_req;
  logic [XLEN-1:0]   if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [XLEN-1:0]   if_rdata;

  logic              d_req;
  logic              d_we;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic [XLEN/8-1:0] d_wstrb;
  logic              d_gnt;
  logic              d_rvalid;
  logic [XLEN-1:0]   d_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_wstrb;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  logic              proto_err;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_gnt, d_rvalid, d_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output proto_err
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  proto_err
  );
endinterface

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - single-outstanding fetch/data memory arbiter
//
// Purpose: shares one memory port between instruction fetch and load/store.
// One transaction at a time (IDLE -> ISSUE -> RESP), data has priority, and a
// starvation counter forces a fetch win after STARVE_LIMIT data wins.
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : riscv_mem_arbiter_if.slave (requesters, memory, proto_err)
module riscv_mem_arbiter
  import riscv_mem_arbiter_pkg::*;
#(
  parameter int XLEN         = ARB_XLEN,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  riscv_mem_arbiter_if.slave  bus
);

  arb_state_t state;
  mem_owner_t owner;
  mem_req_t   req_q;
  logic [3:0] starve_cnt;
  logic       flushed;
  logic       proto_err_q;

  logic starved;
  logic data_win;
  logic fetch_win;
  logic in_issue;
  logic resp_done;
  logic drop_fetch;

  assign starved   = (starve_cnt == 4'(STARVE_LIMIT));
  // Gated with rst so no requester sees a grant while the block is held in reset.
  assign data_win  = !rst && (state == ARB_IDLE) &&
                     data_wins(bus.d_req, bus.if_req, starved);
  assign fetch_win = !rst && (state == ARB_IDLE) && !data_win && bus.if_req;
  assign in_issue  = (state == ARB_ISSUE);
  assign resp_done = (state == ARB_RESP) && bus.mem_rvalid;
  // A flush arriving with the response itself also discards it.
  assign drop_fetch = flushed || bus.if_flush;

  assign bus.d_gnt  = data_win;
  assign bus.if_gnt = fetch_win;

  assign bus.d_rvalid  = resp_done && (owner == OWNER_DATA);
  assign bus.if_rvalid = resp_done && (owner == OWNER_IFETCH) && !drop_fetch;
  assign bus.d_rdata   = bus.d_rvalid  ? bus.mem_rdata : {XLEN{1'b0}};
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : {XLEN{1'b0}};

  assign bus.mem_req   = in_issue;
  assign bus.mem_we    = in_issue && req_q.we;
  assign bus.mem_addr  = in_issue ? req_q.addr  : '0;
  assign bus.mem_wdata = in_issue ? req_q.wdata : '0;
  assign bus.mem_wstrb = in_issue ? req_q.wstrb : '0;

  assign bus.proto_err = proto_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ARB_IDLE;
      owner       <= OWNER_IFETCH;
      req_q       <= '0;
      starve_cnt  <= '0;
      flushed     <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      // Only a response while waiting in RESP is legal; any other is flagged
      // and otherwise ignored.
      if (bus.mem_rvalid && (state != ARB_RESP)) begin
        proto_err_q <= 1'b1;
      end

      case (state)
        ARB_IDLE: begin
          if (data_win) begin
            owner <= OWNER_DATA;
            req_q <= '{we: bus.d_we, addr: bus.d_addr,
                       wdata: bus.d_wdata, wstrb: bus.d_wstrb};
            state <= ARB_ISSUE;
            if (bus.if_req) begin
              if (!starved) begin
                starve_cnt <= starve_cnt + 4'd1;
              end
            end else begin
              starve_cnt <= '0;
            end
          end else if (fetch_win) begin
            owner      <= OWNER_IFETCH;
            req_q      <= '{we: 1'b0, addr: bus.if_addr, wdata: '0, wstrb: '1};
            state      <= ARB_ISSUE;
            starve_cnt <= '0;
          end
        end

        ARB_ISSUE: begin
          if ((owner == OWNER_IFETCH) && bus.if_flush) begin
            flushed <= 1'b1;
          end
          if (bus.mem_gnt) begin
            state <= ARB_RESP;
          end
        end

        ARB_RESP: begin
          if (bus.mem_rvalid) begin
            state   <= ARB_IDLE;
            flushed <= 1'b0;
          end else if ((owner == OWNER_IFETCH) && bus.if_flush) begin
            flushed <= 1'b1;
          end
        end

        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - self-checking bench for riscv_mem_arbiter
module tb_riscv_mem_arbiter;

  localparam int XLEN  = 32;
  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_mem_arbiter_if #(.XLEN(XLEN)) bus();

  riscv_mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Requester model: pending requests held until granted.
  bit          pf;
  logic [31:0] pf_addr;
  bit          pd;
  bit          pd_we;
  logic [31:0] pd_addr;
  logic [31:0] pd_wdata;
  logic [3:0]  pd_wstrb;
  int          streak;
  string       order;
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_order(input string tag, input string exp);
    checks++;
    assert (order == exp) else begin
      errors++;
      $error("FAIL %s observed=%s expected=%s", tag, order, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_reqs();
    bus.if_req  = pf;
    bus.if_addr = pf_addr;
    bus.d_req   = pd;
    bus.d_we    = pd_we;
    bus.d_addr  = pd_addr;
    bus.d_wdata = pd_wdata;
    bus.d_wstrb = pd_wstrb;
  endtask

  task automatic new_reqs(input bit want_f, input bit want_d);
    if (!pf && want_f) begin
      pf      = 1'b1;
      pf_addr = 32'($urandom_range(0, 63)) << 2;
    end
    if (!pd && want_d) begin
      pd       = 1'b1;
      pd_we    = 1'($urandom);
      pd_addr  = 32'($urandom_range(0, 63)) << 2;
      pd_wdata = $urandom;
      pd_wstrb = 4'($urandom_range(1, 15));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_if_gnt"}, bus.if_gnt, 0);
    chk({tag, "_d_gnt"}, bus.d_gnt, 0);
    chk({tag, "_if_rvalid"}, bus.if_rvalid, 0);
    chk({tag, "_d_rvalid"}, bus.d_rvalid, 0);
    chk({tag, "_if_rdata"}, bus.if_rdata, 0);
    chk({tag, "_d_rdata"}, bus.d_rdata, 0);
    chk({tag, "_mem_req"}, bus.mem_req, 0);
    chk({tag, "_mem_we"}, bus.mem_we, 0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, "_mem_wstrb"}, bus.mem_wstrb, 0);
    chk({tag, "_proto_err"}, bus.proto_err, 0);
  endtask

  // One arbitration round: capture, gnt_wait stalled issue cycles, the
  // accepted issue cycle, resp_wait empty response cycles, then the response.
  // flush_it pulses if_flush in the cycle just before the response.
  task automatic txn(input int gnt_wait, input int resp_wait, input bit flush_it);
    bit          dwin;
    bit          fwin;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [31:0] tmp;
    logic [3:0]  wstrb;
    drive_reqs();
    bus.mem_gnt    = 1'($urandom);
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    bus.if_flush   = 1'b0;
    dwin = pd && !(pf && streak == LIMIT);
    fwin = !dwin && pf;
    #2;
    chk("cap_if_gnt", bus.if_gnt, fwin);
    chk("cap_d_gnt", bus.d_gnt, dwin);
    chk("cap_mem_req", bus.mem_req, 0);
    if (bus.d_gnt) order = {order, "D"};
    else if (bus.if_gnt) order = {order, "F"};
    if (!dwin && !fwin) begin
      tick();
      return;
    end
    if (dwin) begin
      we = pd_we; addr = pd_addr; wdata = pd_wdata; wstrb = pd_wstrb;
      streak = pf ? ((streak < LIMIT) ? streak + 1 : streak) : 0;
      pd = 1'b0;
    end else begin
      we = 1'b0; addr = pf_addr; wdata = '0; wstrb = 4'hF;
      streak = 0;
      pf = 1'b0;
    end
    tick();
    drive_reqs();
    for (int i = 0; i <= gnt_wait; i++) begin
      bus.mem_gnt  = (i == gnt_wait);
      bus.if_flush = flush_it && (resp_wait == 0) && (i == gnt_wait);
      #2;
      chk("iss_mem_req", bus.mem_req, 1);
      chk("iss_mem_we", bus.mem_we, we);
      chk("iss_mem_addr", bus.mem_addr, addr);
      chk("iss_mem_wdata", bus.mem_wdata, wdata);
      chk("iss_mem_wstrb", bus.mem_wstrb, wstrb);
      chk("iss_if_gnt", bus.if_gnt, 0);
      chk("iss_d_gnt", bus.d_gnt, 0);
      chk("iss_if_rvalid", bus.if_rvalid, 0);
      chk("iss_d_rvalid", bus.d_rvalid, 0);
      tick();
    end
    for (int i = 0; i < resp_wait; i++) begin
      bus.mem_gnt  = 1'($urandom);
      bus.if_flush = flush_it && (i == resp_wait - 1);
      #2;
      chk("rw_mem_req", bus.mem_req, 0);
      chk("rw_if_gnt", bus.if_gnt, 0);
      chk("rw_d_gnt", bus.d_gnt, 0);
      chk("rw_if_rvalid", bus.if_rvalid, 0);
      chk("rw_d_rvalid", bus.d_rvalid, 0);
      tick();
    end
    bus.if_flush   = 1'b0;
    bus.mem_gnt    = 1'($urandom);
    bus.mem_rvalid = 1'b1;
    if (we) begin
      rd  = $urandom;
      tmp = mem_rd(addr);
      for (int b = 0; b < 4; b++) if (wstrb[b]) tmp[8*b +: 8] = wdata[8*b +: 8];
      mem[addr] = tmp;
    end else begin
      rd = mem_rd(addr);
    end
    bus.mem_rdata = rd;
    #2;
    chk("rsp_d_rvalid", bus.d_rvalid, dwin);
    chk("rsp_d_rdata", bus.d_rdata, dwin ? rd : 32'h0);
    chk("rsp_if_rvalid", bus.if_rvalid, fwin && !flush_it);
    chk("rsp_if_rdata", bus.if_rdata, (fwin && !flush_it) ? rd : 32'h0);
    chk("rsp_mem_req", bus.mem_req, 0);
    chk("rsp_gnts", {bus.if_gnt, bus.d_gnt}, 0);
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    streak = 0;
  endtask

  initial begin
    rst = 1'b1;
    pf = 0; pf_addr = 0; pd = 0; pd_we = 0; pd_addr = 0; pd_wdata = 0; pd_wstrb = 0;
    streak = 0;
    order = "";
    drive_reqs();
    bus.if_flush = 0; bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
    tick();
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    tick();

    // Lone fetch.
    mem[32'h100] = 32'hDEAD_BEEF;
    pf = 1; pf_addr = 32'h100;
    order = "";
    txn(0, 0, 0);
    chk_order("lone_fetch_order", "F");

    // Collision: store and fetch together, data first.
    pf = 1; pf_addr = 32'h40;
    pd = 1; pd_we = 1; pd_addr = 32'h20; pd_wdata = 32'h55; pd_wstrb = 4'hF;
    order = "";
    txn(0, 0, 0);
    txn(0, 0, 0);
    chk_order("collision_order", "DF");
    chk("collision_store", mem[32'h20], 32'h55);

    // Backpressure with a waiting fetch.
    pf = 1; pf_addr = 32'h140;
    pd = 1; pd_we = 0; pd_addr = 32'h80;
    order = "";
    txn(5, 1, 0);
    txn(0, 0, 0);
    chk_order("backpressure_order", "DF");

    // Flush of an outstanding fetch, then a normal fetch.
    mem[32'h300] = 32'h1234_5678;
    pf = 1; pf_addr = 32'h200;
    order = "";
    txn(0, 1, 1);
    pf = 1; pf_addr = 32'h300;
    txn(0, 1, 0);
    chk_order("flush_order", "FF");

    // Starvation: both requesters always busy.
    order = "";
    for (int n = 0; n < 10; n++) begin
      new_reqs(1, 1);
      txn($urandom_range(0, 2), $urandom_range(0, 1), 0);
    end
    chk_order("starve_order", "DDDDFDDDDF");

    // Randomized traffic.
    for (int n = 0; n < 300; n++) begin
      new_reqs($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0);
      txn($urandom_range(0, 3), $urandom_range(0, 2), $urandom_range(0, 3) == 0);
    end

    // Protocol error: response while request still unaccepted.
    do_reset();
    pf = 1; pf_addr = 32'h24;
    drive_reqs();
    bus.mem_gnt = 0; bus.mem_rvalid = 0;
    #2;
    chk("perr_cap_if_gnt", bus.if_gnt, 1);
    tick();
    pf = 0;
    drive_reqs();
    bus.mem_rvalid = 1;
    bus.mem_rdata  = 32'hCAFE_0001;
    #2;
    chk("perr_iss_if_rvalid", bus.if_rvalid, 0);
    chk("perr_iss_d_rvalid", bus.d_rvalid, 0);
    tick();
    bus.mem_rvalid = 0;
    #2;
    chk("perr_iss_flag", bus.proto_err, 1);
    chk("perr_iss_still_req", bus.mem_req, 1);
    chk("perr_iss_addr", bus.mem_addr, 32'h24);

    // Reset while waiting for a response, then a late response.
    do_reset();
    #1;
    chk("rst_clears_perr", bus.proto_err, 0);
    pf = 1; pf_addr = 32'h44;
    drive_reqs();
    #2;
    chk("rr_if_gnt", bus.if_gnt, 1);
    tick();
    pf = 0;
    drive_reqs();
    bus.mem_gnt = 1;
    tick();
    bus.mem_gnt = 0;
    #2;
    chk("rr_in_resp_mem_req", bus.mem_req, 0);
    rst = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    tick();
    rst = 1'b0;
    streak = 0;
    bus.mem_rvalid = 1;
    bus.mem_rdata  = 32'hBAD0_BAD0;
    #2;
    chk("late_if_rvalid", bus.if_rvalid, 0);
    chk("late_if_rdata", bus.if_rdata, 0);
    tick();
    bus.mem_rvalid = 0;
    #2;
    chk("late_perr", bus.proto_err, 1);
    chk("late_idle_mem_req", bus.mem_req, 0);
    rst = 1'b1;
    #2;
    chk("final_rst_perr", bus.proto_err, 0);
    tick();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
